picocode_loader: RTL and testbench

- Sequences code upload into the picocode RAM and switches the CPU instruction source between ROM and RAM.
- Receives a framed byte stream from the UART receiver, assembles 18-bit instruction words and writes them to consecutive RAM addresses.
- While loading, it drives the wrapper's ram_wr_en/ram_address/ram_data_in with remap low. After a verified load it asserts remap and holds the CPU in reset so execution restarts at address 0 from RAM.

---
 rtl/picocode_loader.sv | 165 ++++++++++++++++
 tb/tb_picocode_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picocode_loader.sv
// Picocode upload sequencer: assembles framed UART bytes into 18-bit words, writes them
// to consecutive picocode RAM addresses and switches the CPU instruction source ROM/RAM.
module picocode_loader #(
    parameter int         ADDR_W     = 10,
    parameter int         DATA_W     = 18,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 5_000_000,
    parameter int         RST_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rom_select,
    output logic              remap,
    output logic              cpu_reset,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              busy,
    output logic              load_ok,
    output logic              load_err,
    output logic [2:0]        dbg_state
);
    localparam int          IDX_W = ADDR_W + 1;
    localparam int          TMO_W = $clog2(TIMEOUT + 1);
    localparam int          RCW   = $clog2(RST_CYCLES + 1);
    localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, B0, B1, B2, CHK, SWITCH} state_t;

    state_t           state, state_next;
    logic [7:0]       len_lo, byte0, byte1, chk_acc;
    logic [IDX_W-1:0] word_cnt, word_idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [RCW-1:0]   sw_cnt;
    logic [15:0]      len_n;
    logic             in_frame, timeout_hit, last_word;
    logic             start_frame, wr_word, set_ok, set_err, set_remap, clr_remap;

    // Handshake: rx_valid is a one-cycle strobe with no backpressure; every strobe seen in a
    // frame state is consumed that cycle, so back-to-back bytes are never dropped.
    assign len_n       = {rx_data, len_lo};
    assign in_frame    = (state inside {LEN_LO, LEN_HI, B0, B1, B2, CHK});
    assign timeout_hit = in_frame && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign last_word   = (word_idx == word_cnt - IDX_W'(1));

    assign busy      = (state != IDLE);
    assign cpu_reset = (state == SWITCH);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        wr_word     = 1'b0;
        set_ok      = 1'b0;
        set_err     = 1'b0;
        set_remap   = 1'b0;
        clr_remap   = 1'b0;
        case (state)
            IDLE: begin
                if (rom_select) begin
                    clr_remap  = 1'b1;
                    state_next = SWITCH;
                end else if (rx_valid && rx_data == SYNC_BYTE && !remap) begin
                    start_frame = 1'b1;
                    state_next  = LEN_LO;
                end
            end
            LEN_LO: if (rx_valid) state_next = LEN_HI;
            LEN_HI: begin
                if (rx_valid) begin
                    if (len_n == 16'd0 || {1'b0, len_n} > DEPTH) begin
                        set_err    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = B0;
                    end
                end
            end
            B0: if (rx_valid) state_next = B1;
            B1: if (rx_valid) state_next = B2;
            B2: begin
                if (rx_valid) begin
                    wr_word    = 1'b1;
                    state_next = last_word ? CHK : B0;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (chk_acc == rx_data) begin
                        set_remap  = 1'b1;
                        set_ok     = 1'b1;
                        state_next = SWITCH;
                    end else begin
                        set_err    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            SWITCH: if (sw_cnt == RCW'(RST_CYCLES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A stalled sender abandons the frame; RAM words already written stay in place.
        if (timeout_hit) begin
            set_err    = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remap       <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            load_ok     <= 1'b0;
            load_err    <= 1'b0;
            len_lo      <= '0;
            byte0       <= '0;
            byte1       <= '0;
            chk_acc     <= '0;
            word_cnt    <= '0;
            word_idx    <= '0;
            tmo_cnt     <= '0;
            sw_cnt      <= '0;
        end else begin
            ram_wr_en <= wr_word;
            if (wr_word) begin
                ram_address <= word_idx[ADDR_W-1:0];
                ram_data_in <= {rx_data[1:0], byte1, byte0};
                word_idx    <= word_idx + IDX_W'(1);
            end
            if (start_frame) begin
                chk_acc  <= '0;
                word_idx <= '0;
                load_ok  <= 1'b0;
                load_err <= 1'b0;
            end else if (in_frame && rx_valid) begin
                chk_acc <= chk_acc ^ rx_data;
            end
            if (rx_valid) begin
                case (state)
                    LEN_LO:  len_lo   <= rx_data;
                    LEN_HI:  word_cnt <= len_n[IDX_W-1:0];
                    B0:      byte0    <= rx_data;
                    B1:      byte1    <= rx_data;
                    default: ;
                endcase
            end
            tmo_cnt <= (in_frame && !rx_valid) ? tmo_cnt + TMO_W'(1) : '0;
            sw_cnt  <= (state == SWITCH) ? sw_cnt + RCW'(1) : '0;
            if (set_remap)      remap <= 1'b1;
            else if (clr_remap) remap <= 1'b0;
            if (set_ok)  load_ok  <= 1'b1;
            if (set_err) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_picocode_loader.sv
// Bench for picocode_loader: frame-level reference model, RAM write scoreboard and
// directed/random scenarios for loading, errors, timeout, source switching and reset.
module tb_picocode_loader;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 18;
    localparam int TIMEOUT    = 100;
    localparam int RST_CYCLES = 16;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rom_select = 1'b0;
    logic              remap, cpu_reset, ram_wr_en, busy, load_ok, load_err;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [2:0]        dbg_state;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int rst_hi_cycles = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [7:0]               frame_q[$];

    picocode_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5),
        .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rom_select(rom_select), .remap(remap), .cpu_reset(cpu_reset),
        .ram_wr_en(ram_wr_en), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .busy(busy), .load_ok(load_ok), .load_err(load_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: every RAM write must match the head of exp_q
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr_en === 1'b1) begin
                logic [ADDR_W+DATA_W-1:0] e;
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got addr=%0h data=%0h exp none", ram_address, ram_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if ({ram_address, ram_data_in} !== e) begin
                        failures++;
                        $display("FAIL ram_write got addr=%0h data=%0h exp addr=%0h data=%0h",
                                 ram_address, ram_data_in, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
            if (cpu_reset === 1'b1) rst_hi_cycles++;
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // driver tasks
    task automatic drive_frame(input int max_gap);
        int gap;
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            rx_data  = frame_q[i];
            rx_valid = 1'b1;
            gap = (i == frame_q.size() - 1) ? 0 : int'($urandom_range(max_gap, 0));
            if (gap > 0) begin
                @(negedge clk);
                rx_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_switch(output int hi);
        hi = 0;
        while (cpu_reset === 1'b1 && hi < 4 * RST_CYCLES) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic restore_rom(output int hi);
        @(negedge clk);
        rom_select = 1'b1;
        @(negedge clk);
        rom_select = 1'b0;
        wait_switch(hi);
    endtask

    task automatic load_hex(input logic [127:0] v, input int nbytes);
        frame_q.delete();
        for (int i = 0; i < nbytes; i++) frame_q.push_back(v[8*(nbytes-1-i) +: 8]);
    endtask

    task automatic build_random(input int n, input bit corrupt);
        logic [7:0] x, b;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        x = 8'(n) ^ 8'(n >> 8);
        for (int i = 0; i < 3 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x ^= b;
        end
        if (corrupt) x ^= 8'($urandom_range(255, 1));
        frame_q.push_back(x);
    endtask

    // reference model: whole-frame view of what a load should write and whether it verifies
    task automatic model_frame(output bit ok);
        int n;
        logic [7:0] x;
        ok = 1'b0;
        n = int'({frame_q[2], frame_q[1]});
        if (n < 1 || n > DEPTH) return;
        x = 8'h00;
        for (int i = 1; i < 3 + 3 * n; i++) x ^= frame_q[i];
        for (int w = 0; w < n; w++)
            exp_q.push_back({ADDR_W'(w), frame_q[3*w+5][1:0], frame_q[3*w+4], frame_q[3*w+3]});
        ok = (x == frame_q[3 + 3 * n]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({remap, cpu_reset, ram_wr_en, busy, load_ok, load_err} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {remap, cpu_reset, ram_wr_en, busy, load_ok, load_err}); end
        checks++; if ({ram_address, ram_data_in} !== '0) begin failures++; $display("FAIL reset_ram_bus got=%0h exp=0", {ram_address, ram_data_in}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_two_word();
        int hi, r0;
        load_hex(128'hA5_02_00_34_12_01_78_56_02_09, 10);
        exp_q.push_back({10'd0, 18'h11234});
        exp_q.push_back({10'd1, 18'h25678});
        r0 = rst_hi_cycles;
        drive_frame(2);
        checks++; if (load_ok !== 1'b1 || load_err !== 1'b0) begin failures++; $display("FAIL two_word_status got ok=%b err=%b exp ok=1 err=0", load_ok, load_err); end
        checks++; if (remap !== 1'b1) begin failures++; $display("FAIL two_word_remap got=%b exp=1", remap); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL two_word_writes got pending=%0d exp=0", exp_q.size()); end
        wait_switch(hi);
        checks++; if (hi != RST_CYCLES) begin failures++; $display("FAIL two_word_cpu_reset_len got=%0d exp=%0d", hi, RST_CYCLES); end
        checks++; if (busy !== 1'b0 || rst_hi_cycles - r0 != RST_CYCLES) begin failures++; $display("FAIL two_word_after_switch got busy=%b hi=%0d exp busy=0 hi=%0d", busy, rst_hi_cycles - r0, RST_CYCLES); end
    endtask

    task automatic test_remap_lock();
        int hi, w0;
        w0 = wr_count;
        load_hex(128'hA5_02_00_34_12_01_78_56_02_09, 10);
        drive_frame(1);
        checks++; if (busy !== 1'b0 || wr_count != w0) begin failures++; $display("FAIL remap_lock_ignored got busy=%b writes=%0d exp busy=0 writes=0", busy, wr_count - w0); end
        checks++; if (load_ok !== 1'b1) begin failures++; $display("FAIL remap_lock_load_ok got=%b exp=1", load_ok); end
        restore_rom(hi);
        checks++; if (hi != RST_CYCLES) begin failures++; $display("FAIL rom_select_cpu_reset_len got=%0d exp=%0d", hi, RST_CYCLES); end
        checks++; if (remap !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rom_select_final got remap=%b busy=%b exp 0 0", remap, busy); end
    endtask

    task automatic test_bad_chk();
        int r0;
        load_hex(128'hA5_02_00_34_12_01_78_56_02_0A, 10);
        exp_q.push_back({10'd0, 18'h11234});
        exp_q.push_back({10'd1, 18'h25678});
        r0 = rst_hi_cycles;
        drive_frame(1);
        checks++; if (load_err !== 1'b1 || load_ok !== 1'b0) begin failures++; $display("FAIL bad_chk_status got ok=%b err=%b exp ok=0 err=1", load_ok, load_err); end
        checks++; if (remap !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bad_chk_idle got remap=%b busy=%b exp 0 0", remap, busy); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bad_chk_writes got pending=%0d exp=0", exp_q.size()); end
        repeat (20) @(negedge clk);
        checks++; if (rst_hi_cycles != r0) begin failures++; $display("FAIL bad_chk_no_cpu_reset got=%0d exp=0", rst_hi_cycles - r0); end
    endtask

    task automatic test_len_errors();
        logic [23:0] lv[2];
        bit ok;
        int w0;
        lv[0] = 24'hA5_00_00;
        lv[1] = 24'hA5_01_04;
        for (int i = 0; i < 2; i++) begin
            load_hex({104'h0, lv[i]}, 3);
            model_frame(ok);
            w0 = wr_count;
            drive_frame(0);
            checks++; if (load_err !== !ok || busy !== 1'b0 || wr_count != w0) begin failures++; $display("FAIL len_error_%0d got err=%b busy=%b writes=%0d exp err=1 busy=0 writes=0", i, load_err, busy, wr_count - w0); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int hi, w0;
        build_random(DEPTH, 1'b0);
        model_frame(ok);
        w0 = wr_count;
        drive_frame(0);
        checks++; if (wr_count - w0 != DEPTH || exp_q.size() != 0) begin failures++; $display("FAIL max_frame_writes got=%0d pending=%0d exp=%0d pending=0", wr_count - w0, exp_q.size(), DEPTH); end
        checks++; if (load_ok !== ok || remap !== ok) begin failures++; $display("FAIL max_frame_status got ok=%b remap=%b exp=%b", load_ok, remap, ok); end
        wait_switch(hi);
        checks++; if (hi != RST_CYCLES) begin failures++; $display("FAIL max_frame_cpu_reset_len got=%0d exp=%0d", hi, RST_CYCLES); end
        restore_rom(hi);
    endtask

    task automatic test_random_frames();
        bit ok, corrupt;
        int hi, n;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(12, 1));
            corrupt = ($urandom_range(2, 0) == 0);
            build_random(n, corrupt);
            model_frame(ok);
            drive_frame(3);
            checks++; if (load_ok !== ok || load_err !== !ok || remap !== ok) begin failures++; $display("FAIL random_%0d_status got ok=%b err=%b remap=%b exp ok=%b", it, load_ok, load_err, remap, ok); end
            checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL random_%0d_writes got pending=%0d exp=0", it, exp_q.size()); end
            if (ok) begin
                wait_switch(hi);
                checks++; if (hi != RST_CYCLES) begin failures++; $display("FAIL random_%0d_cpu_reset_len got=%0d exp=%0d", it, hi, RST_CYCLES); end
                restore_rom(hi);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k, hi, w0;
        load_hex(128'hA5_02_00_11, 4);
        w0 = wr_count;
        drive_frame(0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_in_frame got busy=%b exp=1", busy); end
        k = 0;
        while (load_err !== 1'b1 && k < 5 * TIMEOUT) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++; if (k != TIMEOUT) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", k, TIMEOUT); end
        checks++; if (busy !== 1'b0 || load_ok !== 1'b0 || wr_count != w0) begin failures++; $display("FAIL timeout_idle got busy=%b ok=%b writes=%0d exp 0 0 0", busy, load_ok, wr_count - w0); end
        build_random(3, 1'b0);
        model_frame(ok);
        drive_frame(2);
        checks++; if (load_ok !== ok || exp_q.size() != 0) begin failures++; $display("FAIL timeout_recover got ok=%b pending=%0d exp ok=%b pending=0", load_ok, exp_q.size(), ok); end
        wait_switch(hi);
        restore_rom(hi);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int hi;
        load_hex(128'hA5_03_00_11, 4);
        drive_frame(0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_frame_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if ({remap, cpu_reset, ram_wr_en, busy, load_ok, load_err} !== 6'b0) begin failures++; $display("FAIL mid_frame_async_reset got=%b exp=000000", {remap, cpu_reset, ram_wr_en, busy, load_ok, load_err}); end
        @(negedge clk);
        rst = 1'b0;
        build_random(4, 1'b0);
        model_frame(ok);
        drive_frame(1);
        checks++; if (load_ok !== ok || remap !== ok || exp_q.size() != 0) begin failures++; $display("FAIL after_reset_load got ok=%b remap=%b pending=%0d exp ok=%b", load_ok, remap, exp_q.size(), ok); end
        repeat (3) @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL mid_switch_cpu_reset got=%b exp=1", cpu_reset); end
        rst = 1'b1;
        #1;
        checks++; if (remap !== 1'b0 || cpu_reset !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_switch_async_reset got remap=%b cpu_reset=%b busy=%b exp 0 0 0", remap, cpu_reset, busy); end
        @(negedge clk);
        rst = 1'b0;
        build_random(2, 1'b0);
        model_frame(ok);
        drive_frame(0);
        checks++; if (load_ok !== ok || exp_q.size() != 0) begin failures++; $display("FAIL after_switch_reset_load got ok=%b pending=%0d exp ok=%b", load_ok, exp_q.size(), ok); end
        wait_switch(hi);
        checks++; if (hi != RST_CYCLES) begin failures++; $display("FAIL after_switch_reset_cpu_reset_len got=%0d exp=%0d", hi, RST_CYCLES); end
        restore_rom(hi);
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_remap_lock();
        test_bad_chk();
        test_len_errors();
        test_back_to_back();
        test_random_frames();
        test_timeout();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
